// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared state encoding and default sizing for mult_bus_arbiter.
package mult_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      OPA,
      OPB,
      WAIT,
      RESP
   } arb_state_e;

   localparam int W_DEF       = 8;
   localparam int TIMEOUT_DEF = 64;

   // Counter must be able to hold the value TIMEOUT itself.
   function automatic int cnt_width(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/mult_arb_pick.sv
// mult_arb_pick: combinational winner select for mult_bus_arbiter.
// Optional feature macro: MULT_ARB_RR_EN (round-robin search from ptr);
// without it, fixed priority with index 0 highest and no ptr port.
module mult_arb_pick
   import mult_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
`ifdef MULT_ARB_RR_EN
   input  logic [PW-1:0]   ptr,
`endif
   output logic [NREQ-1:0] gnt_oh,
   output logic [PW-1:0]   idx
);

   logic [PW-1:0] sel;

   // Scan from the lowest search offset last so it overrides higher ones.
   always_comb begin
      gnt_oh = '0;
      idx    = '0;
      sel    = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef MULT_ARB_RR_EN
         sel = PW'((int'(ptr) + k) % NREQ);
`else
         sel = PW'(k);
`endif
         if (req[sel]) begin
            gnt_oh      = '0;
            gnt_oh[sel] = 1'b1;
            idx         = sel;
         end
      end
   end

endmodule

// File: rtl/mult_bus_arbiter.sv
// mult_bus_arbiter: shares one shared-bus multiplier among NREQ requesters.
// Sequence per transaction: IDLE(grant) START OPA OPB WAIT.. RESP.
// Optional feature macro: MULT_ARB_RR_EN selects round-robin arbitration;
// default build is fixed priority (lowest index wins).
// The enclosing level owns the tri-state onto databus using
// mult_bus_oe / mult_bus_out; mult_bus_in is the resolved bus.
module mult_bus_arbiter
   import mult_arb_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int W       = W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] opa,
   input  logic [NREQ*W-1:0] opb,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [2*W-1:0]    rsp_data,
   output logic              rsp_err,
   output logic              mult_start,
   output logic [W-1:0]      mult_bus_out,
   output logic              mult_bus_oe,
   input  logic [W-1:0]      mult_bus_in,
   input  logic              mult_msb_out,
   input  logic              mult_lsb_out,
   input  logic              mult_done
);

   localparam int PW = $clog2(NREQ);
   localparam int CW = cnt_width(TIMEOUT);
   localparam logic [NREQ-1:0] ONE = NREQ'(1);

   arb_state_e                 state;
   logic [W-1:0]               a_q, b_q;
   logic [PW-1:0]              idx_q;
   logic [2*W-1:0]             res_q, res_nxt;
   logic [CW-1:0]              cnt_q;
   logic [NREQ-1:0]            pick_oh;
   logic [PW-1:0]              pick_idx;
   logic [NREQ-1:0][W-1:0]     opa_v, opb_v;

   assign opa_v = opa;
   assign opb_v = opb;

`ifdef MULT_ARB_RR_EN
   logic [PW-1:0] ptr_q;

   mult_arb_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
      .req    (req),
      .ptr    (ptr_q),
      .gnt_oh (pick_oh),
      .idx    (pick_idx)
   );

   // Advance the round-robin start point just past each winner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr_q <= '0;
      else if (state == IDLE && |req)
         ptr_q <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
   end
`else
   mult_arb_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
      .req    (req),
      .gnt_oh (pick_oh),
      .idx    (pick_idx)
   );
`endif

   // Result as it will be after this edge's byte strobes; MSB and LSB may both fire.
   always_comb begin
      res_nxt = res_q;
      if (mult_msb_out) res_nxt[2*W-1:W] = mult_bus_in;
      if (mult_lsb_out) res_nxt[W-1:0]   = mult_bus_in;
   end

   // Transaction FSM; every output is registered and set on entry to its state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         a_q          <= '0;
         b_q          <= '0;
         idx_q        <= '0;
         res_q        <= '0;
         cnt_q        <= '0;
         gnt          <= '0;
         rsp_valid    <= '0;
         rsp_data     <= '0;
         rsp_err      <= 1'b0;
         mult_start   <= 1'b0;
         mult_bus_oe  <= 1'b0;
         mult_bus_out <= '0;
      end else begin
         gnt          <= '0;
         rsp_valid    <= '0;
         rsp_data     <= '0;
         rsp_err      <= 1'b0;
         mult_start   <= 1'b0;
         mult_bus_oe  <= 1'b0;
         mult_bus_out <= '0;
         unique case (state)
            IDLE: begin
               if (|req) begin
                  a_q        <= opa_v[pick_idx];
                  b_q        <= opb_v[pick_idx];
                  idx_q      <= pick_idx;
                  res_q      <= '0;
                  gnt        <= pick_oh;
                  mult_start <= 1'b1;
                  state      <= START;
               end
            end
            START: begin
               mult_bus_oe  <= 1'b1;
               mult_bus_out <= a_q;
               state        <= OPA;
            end
            OPA: begin
               mult_bus_oe  <= 1'b1;
               mult_bus_out <= b_q;
               state        <= OPB;
            end
            OPB: begin
               cnt_q <= '0;
               state <= WAIT;
            end
            WAIT: begin
               res_q <= res_nxt;
               cnt_q <= cnt_q + 1'b1;
               if (mult_done) begin
                  rsp_valid <= ONE << idx_q;
                  rsp_data  <= res_nxt;
                  state     <= RESP;
               end else if ((cnt_q + 1'b1) == CW'(TIMEOUT)) begin
                  rsp_valid <= ONE << idx_q;
                  rsp_data  <= res_nxt;
                  rsp_err   <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_bus_arbiter.sv
// tb_mult_bus_arbiter: directed bench with a behavioural shared-bus multiplier.
module tb_mult_bus_arbiter;

   localparam int NREQ    = 4;
   localparam int W       = 8;
   localparam int TIMEOUT = 64;

`ifdef MULT_ARB_RR_EN
   localparam logic [3:0] FIRST  = 4'b1000;
   localparam logic [3:0] SECOND = 4'b0010;
   localparam logic [15:0] FIRST_P  = 16'h009C;
   localparam logic [15:0] SECOND_P = 16'h002A;
`else
   localparam logic [3:0] FIRST  = 4'b0010;
   localparam logic [3:0] SECOND = 4'b1000;
   localparam logic [15:0] FIRST_P  = 16'h002A;
   localparam logic [15:0] SECOND_P = 16'h009C;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [31:0] opa, opb;
   logic [3:0]  gnt, rsp_valid;
   logic [15:0] rsp_data;
   logic        rsp_err, mult_start, mult_bus_oe;
   logic [7:0]  mult_bus_out, mult_bus_in;
   logic        m_msb, m_lsb, m_done;
   logic [7:0]  m_data, ma;
   logic [15:0] prod;
   int          mst;
   bit          hang;
   bit          st_d1, st_d2;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   // Resolved databus: arbiter drive wins, otherwise the multiplier's byte.
   assign mult_bus_in = mult_bus_oe ? mult_bus_out : ((m_msb || m_lsb) ? m_data : 8'h00);

   mult_bus_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req),
      .opa          (opa),
      .opb          (opb),
      .gnt          (gnt),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .rsp_err      (rsp_err),
      .mult_start   (mult_start),
      .mult_bus_out (mult_bus_out),
      .mult_bus_oe  (mult_bus_oe),
      .mult_bus_in  (mult_bus_in),
      .mult_msb_out (m_msb),
      .mult_lsb_out (m_lsb),
      .mult_done    (m_done)
   );

   // Multiplier: start, A, B on consecutive edges; then MSB, then LSB with done.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mst <= 0; m_msb <= 1'b0; m_lsb <= 1'b0; m_done <= 1'b0;
         m_data <= 8'h00; ma <= 8'h00; prod <= 16'h0000;
      end else begin
         case (mst)
            0: if (mult_start) mst <= 1;
            1: begin ma <= mult_bus_in; mst <= 2; end
            2: begin
               prod <= {8'h00, ma} * {8'h00, mult_bus_in};
               if (hang) mst <= 0;
               else begin
                  m_msb  <= 1'b1;
                  m_data <= 8'(({8'h00, ma} * {8'h00, mult_bus_in}) >> 8);
                  mst    <= 3;
               end
            end
            3: begin
               m_msb <= 1'b0; m_lsb <= 1'b1; m_done <= 1'b1;
               m_data <= prod[7:0]; mst <= 4;
            end
            default: begin
               m_lsb <= 1'b0; m_done <= 1'b0; m_data <= 8'h00; mst <= 0;
            end
         endcase
      end
   end

   // Bus hygiene: oe only in the two cycles after a start cycle, never with a strobe.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         checks++;
         if (mult_bus_oe && (!(st_d1 || st_d2) || m_msb || m_lsb)) begin
            failures++;
            $display("FAIL bus_hygiene: oe=%b st_d1=%b st_d2=%b msb=%b lsb=%b at %0t",
                     mult_bus_oe, st_d1, st_d2, m_msb, m_lsb, $time);
         end
      end
      st_d2 = st_d1;
      st_d1 = mult_start && (rst_n === 1'b1);
   end

   task automatic wait_gnt(input int budget, output bit got);
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         if (gnt != 4'b0000) got = 1'b1;
      end
   endtask

   task automatic wait_rsp(input int budget, output int n, output bit got);
      got = 1'b0;
      n   = 0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         n++;
         if (rsp_valid != 4'b0000) got = 1'b1;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; req = 4'b0000; opa = '0; opb = '0; hang = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (gnt !== 4'b0000 || rsp_valid !== 4'b0000) begin
         failures++; $display("FAIL reset_gnt_rsp: gnt=%b rsp_valid=%b want 0000/0000", gnt, rsp_valid);
      end
      checks++;
      if (rsp_data !== 16'h0000 || rsp_err !== 1'b0) begin
         failures++; $display("FAIL reset_rsp_data: data=%h err=%b want 0000/0", rsp_data, rsp_err);
      end
      checks++;
      if (mult_start !== 1'b0 || mult_bus_oe !== 1'b0 || mult_bus_out !== 8'h00) begin
         failures++; $display("FAIL reset_bus: start=%b oe=%b out=%h want 0/0/00", mult_start, mult_bus_oe, mult_bus_out);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0000 || mult_start !== 1'b0) begin
         failures++; $display("FAIL idle_no_req: gnt=%b start=%b want 0000/0", gnt, mult_start);
      end
   endtask

   task automatic test_single;
      bit got; int n;
      opa[7:0] = 8'h03; opb[7:0] = 8'h05; req = 4'b0001;
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt: got %b want 0001", gnt); end
      checks++;
      if (mult_start !== 1'b1 || mult_bus_oe !== 1'b0) begin
         failures++; $display("FAIL single_start: start=%b oe=%b want 1/0", mult_start, mult_bus_oe);
      end
      req = 4'b0000;
      @(negedge clk);
      checks++;
      if (mult_bus_oe !== 1'b1 || mult_bus_out !== 8'h03 || mult_start !== 1'b0 || gnt !== 4'b0000) begin
         failures++; $display("FAIL single_opa: oe=%b out=%h start=%b gnt=%b want 1/03/0/0000",
                              mult_bus_oe, mult_bus_out, mult_start, gnt);
      end
      @(negedge clk);
      checks++;
      if (mult_bus_oe !== 1'b1 || mult_bus_out !== 8'h05) begin
         failures++; $display("FAIL single_opb: oe=%b out=%h want 1/05", mult_bus_oe, mult_bus_out);
      end
      @(negedge clk);
      checks++;
      if (mult_bus_oe !== 1'b0 || mult_bus_out !== 8'h00) begin
         failures++; $display("FAIL single_release: oe=%b out=%h want 0/00", mult_bus_oe, mult_bus_out);
      end
      wait_rsp(20, n, got);
      checks++;
      if (!got || n != 2) begin failures++; $display("FAIL single_latency: got=%0d n=%0d want 1/2", got, n); end
      checks++;
      if (rsp_valid !== 4'b0001 || rsp_data !== 16'h000F || rsp_err !== 1'b0) begin
         failures++; $display("FAIL single_rsp: valid=%b data=%h err=%b want 0001/000F/0", rsp_valid, rsp_data, rsp_err);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 4'b0000 || rsp_data !== 16'h0000) begin
         failures++; $display("FAIL single_rsp_pulse: valid=%b data=%h want 0000/0000", rsp_valid, rsp_data);
      end
   endtask

   task automatic test_max_operands;
      bit got; int n;
      opa[23:16] = 8'hFF; opb[23:16] = 8'hFF; req = 4'b0100;
      wait_gnt(10, got);
      checks++;
      if (!got || gnt !== 4'b0100) begin failures++; $display("FAIL max_gnt: got=%0d gnt=%b want 1/0100", got, gnt); end
      req = 4'b0000;
      wait_rsp(20, n, got);
      checks++;
      if (!got || n != 5) begin failures++; $display("FAIL max_latency: got=%0d n=%0d want 1/5", got, n); end
      checks++;
      if (rsp_valid !== 4'b0100 || rsp_data !== 16'hFE01 || rsp_err !== 1'b0) begin
         failures++; $display("FAIL max_rsp: valid=%b data=%h err=%b want 0100/FE01/0", rsp_valid, rsp_data, rsp_err);
      end
   endtask

   task automatic test_timeout;
      bit got; int n;
      hang = 1'b1;
      opa[31:24] = 8'h02; opb[31:24] = 8'h03; req = 4'b1000;
      wait_gnt(10, got);
      checks++;
      if (!got || gnt !== 4'b1000) begin failures++; $display("FAIL to_gnt: got=%0d gnt=%b want 1/1000", got, gnt); end
      req = 4'b0000;
      wait_rsp(TIMEOUT + 20, n, got);
      checks++;
      if (!got || n != TIMEOUT + 3) begin
         failures++; $display("FAIL to_latency: got=%0d n=%0d want 1/%0d", got, n, TIMEOUT + 3);
      end
      checks++;
      if (rsp_valid !== 4'b1000 || rsp_err !== 1'b1 || rsp_data !== 16'h0000) begin
         failures++; $display("FAIL to_rsp: valid=%b err=%b data=%h want 1000/1/0000", rsp_valid, rsp_err, rsp_data);
      end
      @(negedge clk);
      checks++;
      if (rsp_err !== 1'b0) begin failures++; $display("FAIL to_err_pulse: err=%b want 0", rsp_err); end
      hang = 1'b0;
      opa[15:8] = 8'h04; opb[15:8] = 8'h05; req = 4'b0010;
      wait_gnt(10, got);
      checks++;
      if (!got || gnt !== 4'b0010) begin failures++; $display("FAIL to_next_gnt: got=%0d gnt=%b want 1/0010", got, gnt); end
      req = 4'b0000;
      wait_rsp(20, n, got);
      checks++;
      if (!got || rsp_valid !== 4'b0010 || rsp_data !== 16'h0014 || rsp_err !== 1'b0) begin
         failures++; $display("FAIL to_next_rsp: valid=%b data=%h err=%b want 0010/0014/0", rsp_valid, rsp_data, rsp_err);
      end
   endtask

   task automatic test_contention;
      bit got; int n;
      opa[15:8] = 8'h07; opb[15:8] = 8'h06;
      opa[31:24] = 8'h0C; opb[31:24] = 8'h0D;
      req = 4'b1010;
      wait_gnt(10, got);
      checks++;
      if (!got || gnt !== FIRST) begin failures++; $display("FAIL cont_gnt1: got=%0d gnt=%b want 1/%b", got, gnt, FIRST); end
      req = req & ~FIRST;
      wait_rsp(20, n, got);
      checks++;
      if (!got || rsp_valid !== FIRST || rsp_data !== FIRST_P) begin
         failures++; $display("FAIL cont_rsp1: valid=%b data=%h want %b/%h", rsp_valid, rsp_data, FIRST, FIRST_P);
      end
      wait_gnt(10, got);
      checks++;
      if (!got || gnt !== SECOND) begin failures++; $display("FAIL cont_gnt2: got=%0d gnt=%b want 1/%b", got, gnt, SECOND); end
      req = 4'b0000;
      wait_rsp(20, n, got);
      checks++;
      if (!got || rsp_valid !== SECOND || rsp_data !== SECOND_P) begin
         failures++; $display("FAIL cont_rsp2: valid=%b data=%h want %b/%h", rsp_valid, rsp_data, SECOND, SECOND_P);
      end
   endtask

   task automatic test_mid_reset;
      bit got; int n;
      opa[7:0] = 8'h0A; opb[7:0] = 8'h0B; req = 4'b0001;
      wait_gnt(10, got);
      checks++;
      if (!got || gnt !== 4'b0001) begin failures++; $display("FAIL mr_gnt: got=%0d gnt=%b want 1/0001", got, gnt); end
      @(negedge clk);
      checks++;
      if (mult_bus_oe !== 1'b1 || mult_bus_out !== 8'h0A) begin
         failures++; $display("FAIL mr_opa: oe=%b out=%h want 1/0A", mult_bus_oe, mult_bus_out);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (mult_bus_oe !== 1'b0 || mult_start !== 1'b0 || gnt !== 4'b0000 ||
          rsp_valid !== 4'b0000 || mult_bus_out !== 8'h00) begin
         failures++; $display("FAIL mr_async: oe=%b start=%b gnt=%b valid=%b out=%h want 0/0/0000/0000/00",
                              mult_bus_oe, mult_start, gnt, rsp_valid, mult_bus_out);
      end
      @(negedge clk);
      checks++;
      if (mult_bus_oe !== 1'b0 || rsp_valid !== 4'b0000 || gnt !== 4'b0000) begin
         failures++; $display("FAIL mr_held: oe=%b valid=%b gnt=%b want 0/0000/0000", mult_bus_oe, rsp_valid, gnt);
      end
      rst_n = 1'b1;
      wait_gnt(10, got);
      checks++;
      if (!got || gnt !== 4'b0001) begin failures++; $display("FAIL mr_regnt: got=%0d gnt=%b want 1/0001", got, gnt); end
      req = 4'b0000;
      wait_rsp(20, n, got);
      checks++;
      if (!got || n != 5 || rsp_valid !== 4'b0001 || rsp_data !== 16'h006E || rsp_err !== 1'b0) begin
         failures++; $display("FAIL mr_rsp: n=%0d valid=%b data=%h err=%b want 5/0001/006E/0",
                              n, rsp_valid, rsp_data, rsp_err);
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_max_operands;
      test_timeout;
      test_contention;
      test_mid_reset;
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
